// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_stage
//  Description : Instruction-fetch stage with the IF/ID pipeline register.
//                Holds the PC, picks the next PC from jr/jump/branch/sequential
//                targets, and keeps saturating stall and flush event counters.
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 PCWrite,
    input  logic                 IF_ID_Write,
    input  logic                 IF_ID_flush,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    input  logic                 jump,
    input  logic [31:0]          jump_target,
    input  logic                 jumpReg,
    input  logic [31:0]          jr_target,
    output logic [31:0]          imem_addr,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          IF_ID_Instruction,
    output logic [31:0]          IF_ID_PCPlus4,
    output logic                 IF_ID_valid,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam logic [31:0]          C_NOP     = 32'h0000_0000;
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [31:0]          pc_q, pc_d;
    logic [31:0]          pc_plus4;
    logic [31:0]          instr_q, instr_d;
    logic [31:0]          pcp4_q, pcp4_d;
    logic                 valid_q, valid_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic [CNT_WIDTH-1:0] flush_q, flush_d;

    // Sequential PC wraps modulo 2^32 with no overflow indication.
    assign pc_plus4 = pc_q + 32'd4;

    // Next-PC select: jr beats jump beats branch beats sequential; a frozen PC
    // simply drops the redirect since the hazard unit re-presents it later.
    always_comb begin
        pc_d = pc_q;
        if (PCWrite) begin
            if (jumpReg)           pc_d = {jr_target[31:2], 2'b00};
            else if (jump)         pc_d = {jump_target[31:2], 2'b00};
            else if (branch_taken) pc_d = {branch_target[31:2], 2'b00};
            else                   pc_d = pc_plus4;
        end
    end

    // IF/ID next state: flush to a bubble overrides a normal load.
    always_comb begin
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        if (IF_ID_flush) begin
            instr_d = C_NOP;
            pcp4_d  = 32'h0000_0000;
            valid_d = 1'b0;
        end else if (IF_ID_Write) begin
            instr_d = imem_rdata;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
        end
    end

    // Event counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!PCWrite && !IF_ID_Write && (stall_q != C_CNT_MAX))
            stall_d = stall_q + C_CNT_ONE;
        if (IF_ID_flush && (flush_q != C_CNT_MAX))
            flush_d = flush_q + C_CNT_ONE;
    end

    // State registers, cleared asynchronously whenever reset is low.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= C_NOP;
            pcp4_q  <= 32'h0000_0000;
            valid_q <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign imem_addr         = pc_q;
    assign IF_ID_Instruction = instr_q;
    assign IF_ID_PCPlus4     = pcp4_q;
    assign IF_ID_valid       = valid_q;
    assign stall_count       = stall_q;
    assign flush_count       = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_stage
//  Description : Directed self-checking bench for if_fetch_stage. The memory
//                model returns the word address as data (word = addr).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_fetch_stage;

    logic        Clk;
    logic        Rst_n;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        IF_ID_flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jumpReg;
    logic [31:0] jr_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_valid;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int checks = 0;
    int errors = 0;

    if_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .CNT_WIDTH (16)
    ) dut (
        .Clk               (Clk),
        .Rst_n             (Rst_n),
        .PCWrite           (PCWrite),
        .IF_ID_Write       (IF_ID_Write),
        .IF_ID_flush       (IF_ID_flush),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .jump              (jump),
        .jump_target       (jump_target),
        .jumpReg           (jumpReg),
        .jr_target         (jr_target),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PCPlus4     (IF_ID_PCPlus4),
        .IF_ID_valid       (IF_ID_valid),
        .stall_count       (stall_count),
        .flush_count       (flush_count)
    );

    assign imem_rdata = imem_addr;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                             input logic [31:0] p4, input logic v,
                             input logic [15:0] sc, input logic [15:0] fc);
        check({tag, ".pc"},    imem_addr, pc);
        check({tag, ".instr"}, IF_ID_Instruction, ins);
        check({tag, ".pcp4"},  IF_ID_PCPlus4, p4);
        check({tag, ".valid"}, {31'd0, IF_ID_valid}, {31'd0, v});
        check({tag, ".stall"}, {16'd0, stall_count}, {16'd0, sc});
        check({tag, ".flush"}, {16'd0, flush_count}, {16'd0, fc});
    endtask

    task automatic clear_redirect();
        branch_taken = 1'b0;
        jump         = 1'b0;
        jumpReg      = 1'b0;
        IF_ID_flush  = 1'b0;
    endtask

    initial begin
        Rst_n = 1'b0;
        PCWrite = 1'b1; IF_ID_Write = 1'b1;
        branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_target = 32'h0;
        jumpReg = 1'b0; jr_target = 32'h0;
        IF_ID_flush = 1'b0;

        // Reset state
        #12;
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
        #1 Rst_n = 1'b1;

        // Sequential fetch from RESET_PC
        tick();
        check_all("seq1", 32'h4, 32'h0, 32'h4, 1'b1, 16'd0, 16'd0);
        tick();
        tick();
        check_all("seq3", 32'hC, 32'h8, 32'hC, 1'b1, 16'd0, 16'd0);
        repeat (5) tick();
        check_all("at20", 32'h20, 32'h1C, 32'h20, 1'b1, 16'd0, 16'd0);

        // Three-cycle stall
        PCWrite = 1'b0; IF_ID_Write = 1'b0;
        repeat (3) tick();
        check_all("stall3", 32'h20, 32'h1C, 32'h20, 1'b1, 16'd3, 16'd0);
        PCWrite = 1'b1; IF_ID_Write = 1'b1;
        tick();
        check_all("unstall", 32'h24, 32'h20, 32'h24, 1'b1, 16'd3, 16'd0);

        // Redirect priority with flush
        jumpReg = 1'b1; jr_target = 32'h100;
        jump = 1'b1; jump_target = 32'h200;
        branch_taken = 1'b1; branch_target = 32'h300;
        IF_ID_flush = 1'b1;
        tick();
        check_all("redir", 32'h100, 32'h0, 32'h0, 1'b0, 16'd3, 16'd1);
        clear_redirect();
        tick();
        check_all("target", 32'h104, 32'h100, 32'h104, 1'b1, 16'd3, 16'd1);

        // Unaligned jr target is forced to a word boundary
        jumpReg = 1'b1; jr_target = 32'h103;
        jump = 1'b1; branch_taken = 1'b1; IF_ID_flush = 1'b1;
        tick();
        check_all("redir_al", 32'h100, 32'h0, 32'h0, 1'b0, 16'd3, 16'd2);
        clear_redirect();
        tick();
        check_all("target2", 32'h104, 32'h100, 32'h104, 1'b1, 16'd3, 16'd2);

        // Jump alone goes to jump_target, branch alone to branch_target
        jump = 1'b1; jump_target = 32'h202; branch_taken = 1'b1;
        tick();
        check("jump_only.pc", imem_addr, 32'h200);
        clear_redirect();
        branch_taken = 1'b1; branch_target = 32'h301;
        tick();
        check("branch_only.pc", imem_addr, 32'h300);
        check("branch_only.instr", IF_ID_Instruction, 32'h200);
        clear_redirect();

        // Flush with write: bubble loaded, PC still advances
        IF_ID_flush = 1'b1;
        tick();
        check_all("flushwr", 32'h304, 32'h0, 32'h0, 1'b0, 16'd3, 16'd3);
        IF_ID_flush = 1'b0;

        // Jump while PC frozen is ignored; IF/ID still loads
        jump = 1'b1; jump_target = 32'h400; PCWrite = 1'b0;
        tick();
        check_all("frozen", 32'h304, 32'h304, 32'h308, 1'b1, 16'd3, 16'd3);
        jump = 1'b0;

        // Stall and flush counted in the same cycle
        IF_ID_Write = 1'b0; IF_ID_flush = 1'b1;
        tick();
        check_all("both", 32'h304, 32'h0, 32'h0, 1'b0, 16'd4, 16'd4);
        IF_ID_flush = 1'b0; PCWrite = 1'b1; IF_ID_Write = 1'b1;
        tick();
        check_all("resume", 32'h308, 32'h304, 32'h308, 1'b1, 16'd4, 16'd4);

        // Asynchronous reset mid-run, checked before any clock edge
        #2 Rst_n = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
        #2 Rst_n = 1'b1;
        tick();
        check_all("post_rst", 32'h4, 32'h0, 32'h4, 1'b1, 16'd0, 16'd0);

        // Stall counter saturation
        PCWrite = 1'b0; IF_ID_Write = 1'b0;
        repeat (65534) tick();
        check("stall_65534", {16'd0, stall_count}, 32'h0000_FFFE);
        tick();
        check("stall_sat", {16'd0, stall_count}, 32'h0000_FFFF);
        repeat (70000 - 65535) tick();
        check("stall_hold", {16'd0, stall_count}, 32'h0000_FFFF);
        check("stall_pc", imem_addr, 32'h4);
        PCWrite = 1'b1; IF_ID_Write = 1'b1;

        // PC wrap at the top of the address space
        jumpReg = 1'b1; jr_target = 32'hFFFF_FFFF;
        tick();
        check("top.pc", imem_addr, 32'hFFFF_FFFC);
        clear_redirect();
        tick();
        check_all("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 16'hFFFF, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
